// File: rtl/iir_coef_ctrl.sv
// iir_coef_ctrl
// Coefficient manager for the two MuxIir biquad channels. Host bytes are
// collected in a 10-byte shadow bank and copied atomically into the active
// coefficient outputs on the first frame-clock rising edge after a commit,
// so a filter never runs with a torn coefficient set. After each swap the
// filters can be held in reset for CLR_FRAMES frames to flush their history.
//
// Optional build macro: IIR_COEF_STABILITY_CHECK_EN
//   When defined, a commit whose shadow B2 has |B2| >= 1.0 (signed Q2.14)
//   is dropped at the frame edge and the sticky err_unstable flag is set.
//
// Ports
//   MCLK        audio master clock (only clock)
//   RST_N       asynchronous active-low reset
//   FSCLK       frame clock, asynchronous to MCLK
//   wr_en       register write strobe; wr_addr[4:0], wr_data[7:0]
//   rd_en       register read strobe;  rd_addr[4:0]
//   rd_data     read data, registered, valid one cycle after rd_en
//   A0..B2      active coefficients (16 bit each), registered
//   iir_rst_n   active-low reset to the MuxIir instances
//   busy        commit in progress (ARMED, SWAP, FLUSH)
//   commit_done one-MCLK pulse when a commit completes
//
// Register map
//   0..9   shadow bytes, little-endian pairs: A0, A1, A2, B1, B2
//   10     CTRL   write: bit0 commit request, bit7 clear sticky flags; reads 0
//   11     STATUS read : {4'b0, err_unstable, overrun, busy, armed}
//   12..31 writes ignored, reads 0

module iir_coef_ctrl #(
  parameter logic [15:0] A0_RST     = 16'h4000,
  parameter logic [15:0] A1_RST     = 16'h0000,
  parameter logic [15:0] A2_RST     = 16'h0000,
  parameter logic [15:0] B1_RST     = 16'h0000,
  parameter logic [15:0] B2_RST     = 16'h0000,
  parameter int unsigned CLR_FRAMES = 2
) (
  input  logic        MCLK,
  input  logic        RST_N,
  input  logic        FSCLK,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  input  logic [4:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [15:0] A0,
  output logic [15:0] A1,
  output logic [15:0] A2,
  output logic [15:0] B1,
  output logic [15:0] B2,
  output logic        iir_rst_n,
  output logic        busy,
  output logic        commit_done
);

  // state | meaning
  // ------+--------------------------------------------------------------
  // IDLE  | no commit pending; CTRL bit0 arms a commit
  // ARMED | waiting for the next frame edge (fs_rise)
  // SWAP  | active set was loaded on entry; iir_rst_n already low if flushing
  // FLUSH | filters held in reset, counting frame edges down to zero

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SWAP  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [7:0] CLR_CNT  = 8'(CLR_FRAMES);
  localparam bit         FLUSH_EN = (CLR_FRAMES != 0);

  state_t      state_q, state_d;
  logic [7:0]  shadow [10];
  logic        fs_s1, fs_s2, fs_s3;
  logic        fs_rise;
  logic [7:0]  frame_cnt;
  logic        overrun, err_unstable;
  logic        ctrl_wr, commit_req, clr_req;
  logic        do_swap, set_unstable, cnt_dec, done;
  logic        b2_unstable;
  logic [7:0]  status;
  logic [7:0]  rd_mux;

  // ---------------------------------------------------------------------
  // Frame clock: two-flop synchroniser plus an edge register. fs_rise is
  // a clean AND of two flops and is high for exactly one MCLK cycle, the
  // third cycle after the FSCLK rising edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      fs_s1 <= 1'b0;
      fs_s2 <= 1'b0;
      fs_s3 <= 1'b0;
    end else begin
      fs_s1 <= FSCLK;
      fs_s2 <= fs_s1;
      fs_s3 <= fs_s2;
    end
  end

  assign fs_rise = fs_s2 & ~fs_s3;

  // ---------------------------------------------------------------------
  // Control register decode
  // ---------------------------------------------------------------------
  assign ctrl_wr    = wr_en && (wr_addr == 5'd10);
  assign commit_req = ctrl_wr && wr_data[0];
  assign clr_req    = ctrl_wr && wr_data[7];

  assign busy   = (state_q != IDLE);
  assign status = {4'b0000, err_unstable, overrun, busy, (state_q == ARMED)};

`ifdef IIR_COEF_STABILITY_CHECK_EN
  // |B2| >= 1.0 in Q2.14 puts the second-order pole on or outside the unit
  // circle, so such a set is never allowed to reach the filters.
  logic signed [15:0] shadow_b2;
  assign shadow_b2   = {shadow[9], shadow[8]};
  assign b2_unstable = (shadow_b2 >= 16'sh4000) || (shadow_b2 <= 16'shC000);
`else
  assign b2_unstable = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Commit FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    do_swap      = 1'b0;
    set_unstable = 1'b0;
    cnt_dec      = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req) state_d = ARMED;
      end
      ARMED: begin
        if (fs_rise) begin
          if (b2_unstable) begin
            set_unstable = 1'b1;
            state_d      = IDLE;
          end else begin
            do_swap = 1'b1;
            state_d = SWAP;
          end
        end
      end
      SWAP: begin
        if (FLUSH_EN) begin
          state_d = FLUSH;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (fs_rise) begin
          cnt_dec = 1'b1;
          if (frame_cnt <= 8'd1) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N)       frame_cnt <= 8'd0;
    else if (do_swap) frame_cnt <= CLR_CNT;
    else if (cnt_dec) frame_cnt <= frame_cnt - 8'd1;
  end

  // ---------------------------------------------------------------------
  // Active coefficients. The load happens on the edge that enters SWAP, so
  // a shadow write issued during the SWAP cycle lands after the copy.
  // ---------------------------------------------------------------------
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      A0 <= A0_RST;
      A1 <= A1_RST;
      A2 <= A2_RST;
      B1 <= B1_RST;
      B2 <= B2_RST;
    end else if (do_swap) begin
      A0 <= {shadow[1], shadow[0]};
      A1 <= {shadow[3], shadow[2]};
      A2 <= {shadow[5], shadow[4]};
      B1 <= {shadow[7], shadow[6]};
      B2 <= {shadow[9], shadow[8]};
    end
  end

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      iir_rst_n   <= 1'b1;
      commit_done <= 1'b0;
    end else begin
      commit_done <= done;
      if (do_swap && FLUSH_EN) iir_rst_n <= 1'b0;
      else if (done)           iir_rst_n <= 1'b1;
    end
  end

  // Clear is applied before the commit is evaluated, so a commit+clear
  // while busy still leaves overrun set.
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      overrun      <= 1'b0;
      err_unstable <= 1'b0;
    end else begin
      if (clr_req) begin
        overrun      <= 1'b0;
        err_unstable <= 1'b0;
      end
      if (commit_req && busy) overrun      <= 1'b1;
      if (set_unstable)       err_unstable <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Shadow bank and read port
  // ---------------------------------------------------------------------
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow[0] <= A0_RST[7:0];
      shadow[1] <= A0_RST[15:8];
      shadow[2] <= A1_RST[7:0];
      shadow[3] <= A1_RST[15:8];
      shadow[4] <= A2_RST[7:0];
      shadow[5] <= A2_RST[15:8];
      shadow[6] <= B1_RST[7:0];
      shadow[7] <= B1_RST[15:8];
      shadow[8] <= B2_RST[7:0];
      shadow[9] <= B2_RST[15:8];
    end else if (wr_en && (wr_addr < 5'd10)) begin
      shadow[wr_addr[3:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    if (rd_addr < 5'd10)       rd_mux = shadow[rd_addr[3:0]];
    else if (rd_addr == 5'd11) rd_mux = status;
  end

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N)     rd_data <= 8'h00;
    else if (rd_en) rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// tb_iir_coef_ctrl
// Self-checking bench for iir_coef_ctrl. A behavioural model (shadow byte
// array, expected active set, sticky flags, busy/armed) predicts register
// reads, coefficient swaps at the frame edge, the flush window and the
// commit_done count. Directed cases cover reset, the reference coefficient
// vector, overrun/clear, a write in the swap cycle, B2 = 1.0 and a reset
// mid-commit; a randomized loop follows. The macro
// IIR_COEF_STABILITY_CHECK_EN selects the matching model behaviour.

module tb_iir_coef_ctrl;

`ifdef IIR_COEF_STABILITY_CHECK_EN
  localparam bit STAB = 1'b1;
`else
  localparam bit STAB = 1'b0;
`endif
  localparam int CLR = 2;

  logic        MCLK  = 1'b0;
  logic        RST_N = 1'b0;
  logic        FSCLK = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  logic [7:0]  rd_data;
  logic [15:0] A0, A1, A2, B1, B2;
  logic        iir_rst_n, busy, commit_done;

  iir_coef_ctrl #(.CLR_FRAMES(CLR)) dut (
    .MCLK        (MCLK),
    .RST_N       (RST_N),
    .FSCLK       (FSCLK),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .A0          (A0),
    .A1          (A1),
    .A2          (A2),
    .B1          (B1),
    .B2          (B2),
    .iir_rst_n   (iir_rst_n),
    .busy        (busy),
    .commit_done (commit_done)
  );

  always #5 MCLK = ~MCLK;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int done_exp = 0;

  logic [7:0]  m_shadow [10];
  logic [15:0] m_act [5];
  bit m_over, m_err, m_busy, m_armed;

  always @(negedge MCLK) if (commit_done === 1'b1) done_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic m_reset();
    m_act[0] = 16'h4000;
    for (int k = 1; k < 5; k++) m_act[k] = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      m_shadow[2*k]   = m_act[k][7:0];
      m_shadow[2*k+1] = m_act[k][15:8];
    end
    m_over = 0; m_err = 0; m_busy = 0; m_armed = 0;
  endtask

  function automatic logic [7:0] exp_rd(input int a);
    if (a < 10) return m_shadow[a];
    if (a == 11) return {4'b0000, m_err, m_over, m_busy, m_armed};
    return 8'h00;
  endfunction

  task automatic chk_active(input string tag);
    chk({tag, "_A0"}, 32'(A0), 32'(m_act[0]));
    chk({tag, "_A1"}, 32'(A1), 32'(m_act[1]));
    chk({tag, "_A2"}, 32'(A2), 32'(m_act[2]));
    chk({tag, "_B1"}, 32'(B1), 32'(m_act[3]));
    chk({tag, "_B2"}, 32'(B2), 32'(m_act[4]));
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < 10) m_shadow[a] = d;
  endtask

  task automatic rd_chk(input int a, input string tag);
    logic [7:0] e;
    e = exp_rd(a);
    rd_en = 1'b1; rd_addr = 5'(a);
    tick();
    rd_en = 1'b0;
    chk(tag, 32'(rd_data), 32'(e));
  endtask

  // Write and read the same byte in one cycle: the read sees the old value.
  task automatic wr_rd_same(input int a, input logic [7:0] d);
    logic [7:0] e;
    e = exp_rd(a);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
    rd_en = 1'b1; rd_addr = 5'(a);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    if (a < 10) m_shadow[a] = d;
    chk("wr_rd_same", 32'(rd_data), 32'(e));
  endtask

  task automatic ctrl(input logic [7:0] d);
    wr(10, d);
    if (d[7]) begin m_over = 0; m_err = 0; end
    if (d[0]) begin
      if (m_busy) m_over = 1;
      else begin m_busy = 1; m_armed = 1; end
    end
  endtask

  task automatic fs_low();
    FSCLK = 1'b0;
    tick();
    tick();
    rd_chk(11, "status_between_frames");
  endtask

  // Drive a frame edge on an armed commit and follow it through to IDLE.
  task automatic finish_commit(input string tag, input bit sw_wr,
                               input int sw_addr, input logic [7:0] sw_data);
    logic [7:0]         snap [10];
    logic signed [15:0] sb2;
    int                 b2;
    bit                 skip;
    FSCLK = 1'b1;
    tick();
    tick();
    chk({tag, "_pre_busy"}, 32'(busy), 32'd1);
    chk_active({tag, "_pre"});
    for (int i = 0; i < 10; i++) snap[i] = m_shadow[i];
    sb2  = {snap[9], snap[8]};
    b2   = int'(sb2);
    skip = STAB && ((b2 >= 16384) || (b2 <= -16384));
    tick();
    m_armed = 0;
    if (skip) begin
      m_err  = 1;
      m_busy = 0;
      chk({tag, "_skip_busy"}, 32'(busy), 32'd0);
      chk({tag, "_skip_rst"}, 32'(iir_rst_n), 32'd1);
      chk_active({tag, "_skip"});
      fs_low();
    end else begin
      for (int k = 0; k < 5; k++) m_act[k] = {snap[2*k+1], snap[2*k]};
      chk_active({tag, "_swap"});
      chk({tag, "_swap_rst"}, 32'(iir_rst_n), 32'd0);
      chk({tag, "_swap_busy"}, 32'(busy), 32'd1);
      if (sw_wr) begin
        wr(sw_addr, sw_data);
        chk_active({tag, "_swapwr"});
        rd_chk(sw_addr, {tag, "_swapwr_rd"});
      end
      fs_low();
      for (int k = 1; k <= CLR; k++) begin
        FSCLK = 1'b1;
        tick();
        tick();
        chk({tag, "_flush_hold"}, 32'(iir_rst_n), 32'd0);
        tick();
        if (k == CLR) begin
          m_busy = 0;
          done_exp++;
          chk({tag, "_flush_release"}, 32'(iir_rst_n), 32'd1);
          chk({tag, "_done_pulse"}, 32'(commit_done), 32'd1);
          chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        end else begin
          chk({tag, "_flush_mid"}, 32'(iir_rst_n), 32'd0);
        end
        fs_low();
      end
    end
    chk({tag, "_done_count"}, 32'(done_seen), 32'(done_exp));
    chk_active({tag, "_end"});
  endtask

  initial begin
    logic [7:0] tp [10];
    int n, a;
    logic [7:0] d;

    tp[0] = 8'h2C; tp[1] = 8'h03; tp[2] = 8'h58; tp[3] = 8'h06; tp[4] = 8'h2C;
    tp[5] = 8'h03; tp[6] = 8'hD7; tp[7] = 8'h51; tp[8] = 8'h75; tp[9] = 8'hE1;

    // Reset state
    m_reset();
    RST_N = 1'b0;
    repeat (3) tick();
    chk_active("rst");
    chk("rst_iir_rst_n", 32'(iir_rst_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_commit_done", 32'(commit_done), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    RST_N = 1'b1;
    tick();
    rd_chk(11, "rst_status");
    rd_chk(1, "rst_shadow_a0_hi");
    rd_chk(20, "rst_unmapped");

    // Reference coefficient vector
    for (int i = 0; i < 10; i++) wr(i, tp[i]);
    rd_chk(7, "tp_rd7");
    wr_rd_same(3, 8'h06);
    ctrl(8'h01);
    rd_chk(11, "tp_armed_status");
    finish_commit("tp", 1'b0, 0, 8'h00);
    chk("tp_A0_const", 32'(A0), 32'h032C);
    chk("tp_A1_const", 32'(A1), 32'h0658);
    chk("tp_A2_const", 32'(A2), 32'h032C);
    chk("tp_B1_const", 32'(B1), 32'h51D7);
    chk("tp_B2_const", 32'(B2), 32'hE175);

    // Overrun while armed, then clear
    wr(0, 8'h11);
    ctrl(8'h01);
    ctrl(8'h01);
    rd_chk(11, "ovr_status");
    ctrl(8'h80);
    rd_chk(11, "ovr_cleared_status");
    finish_commit("ovr", 1'b0, 0, 8'h00);

    // Write to byte 0 during the SWAP cycle
    wr(0, 8'h5A);
    ctrl(8'h01);
    finish_commit("swapwr", 1'b1, 0, 8'hAA);
    chk("swapwr_A0_lo", 32'(A0[7:0]), 32'h5A);

    // B2 = +1.0
    wr(8, 8'h00);
    wr(9, 8'h40);
    ctrl(8'h01);
    finish_commit("b2_one", 1'b0, 0, 8'h00);
    rd_chk(11, "b2_one_status");
    ctrl(8'h80);
    rd_chk(11, "b2_one_cleared");

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      n = int'($urandom_range(1, 6));
      for (int j = 0; j < n; j++) begin
        a = int'($urandom_range(0, 31));
        if (a == 10) a = 11;
        d = 8'($urandom);
        wr(a, d);
      end
      if ($urandom_range(0, 1) == 1) wr_rd_same(int'($urandom_range(0, 9)), 8'($urandom));
      rd_chk(int'($urandom_range(0, 31)), "rnd_rd");
      ctrl({$urandom_range(0, 1) == 1, 6'b000000, 1'b1});
      if ($urandom_range(0, 1) == 1) ctrl(8'h01);
      rd_chk(11, "rnd_armed_status");
      finish_commit("rnd", $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 9)), 8'($urandom));
      if ($urandom_range(0, 2) == 0) ctrl(8'h80);
    end

    // Reset in the middle of a flush
    wr(0, 8'h11); wr(1, 8'h22); wr(8, 8'h00); wr(9, 8'h10);
    ctrl(8'h01);
    FSCLK = 1'b1;
    tick(); tick(); tick();
    chk("midrst_A0_swapped", 32'(A0), 32'h2211);
    tick();
    RST_N = 1'b0;
    #2;
    m_reset();
    chk_active("midrst");
    chk("midrst_iir_rst_n", 32'(iir_rst_n), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    FSCLK = 1'b0;
    tick();
    RST_N = 1'b1;
    repeat (4) tick();
    rd_chk(0, "midrst_shadow0");
    rd_chk(11, "midrst_status");
    chk("midrst_done_count", 32'(done_seen), 32'(done_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
